cflog_write_arbiter: RTL and testbench
======================================

Name: cflog_write_arbiter

Overview:
- Shares the single CF-Log write port between two control-flow entry producers: port 0 is the branch/return address logger, port 1 is the speculated-subpath ID encoder.
- Sequences appends into the LOG region, tracks the write pointer, and detects log-full.
- On full, it requests a TCB flush (report + clear) and stalls both producers until the flush is acknowledged.
- Its writes are TCB-originated and therefore exempt from the boundary monitor's LOG-write check.

Parameters:
- LOG_MIN, 16'h01b0, byte address of the first log word.
- LOG_SIZE, 16'h0100, log capacity in 2-byte words; must be ≥ 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req0  in  1  producer 0 write request; held high until granted
- data0  in  16  producer 0 entry
- req1  in  1  producer 1 write request; held high until granted
- data1  in  16  producer 1 entry
- gnt0  out  1  grant to producer 0, combinational, one-cycle pulse
- gnt1  out  1  grant to producer 1, combinational, one-cycle pulse
- log_we  out  1  log memory write enable, registered
- log_addr  out  16  log memory byte address, registered
- log_wdata  out  16  log memory write data, registered
- log_idx  out  16  number of entries currently in the log
- log_full  out  1  high while in state FULL
- flush_req  out  1  request to TCB to report and clear the log
- flush_ack  in  1  TCB done; one-cycle pulse
- kill  in  1  boundary-monitor violation, level

Behaviour:
- Reset (async, reset_n=0):
  - state=RUN, log_idx=0, last_gnt=1 so producer 0 wins the first contest.
  - log_we=0, log_addr=0, log_wdata=0, flush_req=0, log_full=0.
- States: RUN, FULL.
- RUN:
  - Grant only when state=RUN and kill=0.
  - Only req0 -> gnt0. Only req1 -> gnt1.
  - Both -> grant the port not granted last (round-robin).
  - At most one gnt per cycle; last_gnt is updated on every grant.
- Write on grant (registered, one cycle after the grant):
  - log_we=1.
  - log_addr = LOG_MIN + 2*log_idx, using the pre-increment log_idx; 16-bit, no wrap check needed since log_idx < LOG_SIZE.
  - log_wdata = granted producer's data.
  - log_idx increments in the same clock edge that registers the write.
  - log_we deasserts the following cycle unless there is another grant; back-to-back grants give one write per cycle.
- Full detection:
  - If a grant makes log_idx == LOG_SIZE, go to FULL on that edge.
  - flush_req=1 and log_full=1 from the next cycle; the final write still issues.
- FULL:
  - No grants; requesters keep req high (stall).
  - flush_req stays high until flush_ack.
  - flush_ack=1 -> log_idx=0, flush_req=0, state=RUN; grants resume the cycle after.
  - flush_ack while in RUN is ignored.
- kill=1, any state, synchronous:
  - log_idx=0, flush_req=0, state=RUN, log_we=0 next cycle, no grants while kill=1.
  - kill has priority over grant and flush_ack.
- Simultaneous grant-that-fills and kill: kill wins; no write issues, log_idx=0.
- Arbitration is lossless: a granted entry is always written; an ungranted request never consumes a slot.
- log_idx never exceeds LOG_SIZE; log_addr never exceeds LOG_MIN + 2*(LOG_SIZE-1).
- Latency: request to write = 1 cycle uncontended; worst case 2 cycles under contention, excluding FULL stall.

Test Plan:
- Single producer: after reset, req0 with data0=16'hC0DE for one cycle -> gnt0 same cycle; next cycle log_we=1, log_addr=16'h01b0, log_wdata=16'hC0DE; log_idx=1.
- Contention (LOG_SIZE=16): req0 and req1 held high for 4 cycles -> grants alternate 0,1,0,1; log_addr sequence 01b0, 01b2, 01b4, 01b6; log_idx=4.
- Fill and flush (LOG_SIZE=4): 4 writes -> 4th write at 16'h01b6, then log_full=1 and flush_req=1. req1 held -> no gnt1 for 10 cycles. Pulse flush_ack -> log_idx=0, gnt1 next cycle, write at 16'h01b0.
- Kill mid-FULL (LOG_SIZE=4): in FULL, assert kill for 1 cycle together with flush_ack -> flush_req=0, log_idx=0, no write that cycle; RUN afterwards.
- Kill vs grant: req0 with kill=1 -> gnt0=0, log_we=0, log_idx unchanged at 0.
- Async reset mid-stream: drop reset_n between clock edges while log_idx=3 -> all outputs 0 immediately, log_idx=0. After release with both req high -> gnt0 first.

Source files
------------

// File: rtl/cflog_write_arbiter.sv
// Two-producer round-robin arbiter that appends entries into the CF-Log region,
// tracks the write pointer and holds producers off while the TCB flushes a full log.
module cflog_write_arbiter #(
    parameter logic [15:0] LOG_MIN  = 16'h01b0,
    parameter logic [15:0] LOG_SIZE = 16'h0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        log_we,
    output logic [15:0] log_addr,
    output logic [15:0] log_wdata,
    output logic [15:0] log_idx,
    output logic        log_full,
    output logic        flush_req,
    input  logic        flush_ack,
    input  logic        kill
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // Handshake: a producer holds reqN high with dataN stable; gntN is a one-cycle
    // combinational pulse in the cycle its entry is accepted, and the write lands next edge.
    state_t      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;   // 1 means producer 1 won the last grant
    logic [15:0] log_idx_q, log_idx_d;
    logic        log_we_q, log_we_d;
    logic [15:0] log_addr_q, log_addr_d;
    logic [15:0] log_wdata_q, log_wdata_d;
    logic        flush_req_q, flush_req_d;
    logic        grant_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            last_gnt_q  <= 1'b1;
            log_idx_q   <= 16'h0000;
            log_we_q    <= 1'b0;
            log_addr_q  <= 16'h0000;
            log_wdata_q <= 16'h0000;
            flush_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            log_idx_q   <= log_idx_d;
            log_we_q    <= log_we_d;
            log_addr_q  <= log_addr_d;
            log_wdata_q <= log_wdata_d;
            flush_req_q <= flush_req_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        log_idx_d   = log_idx_q;
        log_we_d    = 1'b0;
        log_addr_d  = log_addr_q;
        log_wdata_d = log_wdata_q;
        flush_req_d = flush_req_q;
        if (kill) begin
            state_d     = ST_RUN;
            log_idx_d   = 16'h0000;
            flush_req_d = 1'b0;
        end else if (state_q == ST_FULL) begin
            if (flush_ack) begin
                state_d     = ST_RUN;
                log_idx_d   = 16'h0000;
                flush_req_d = 1'b0;
            end
        end else if (gnt0 || gnt1) begin
            // log_idx is always below LOG_SIZE in RUN, so the address stays in range
            log_we_d    = 1'b1;
            log_addr_d  = LOG_MIN + {log_idx_q[14:0], 1'b0};
            log_wdata_d = gnt1 ? data1 : data0;
            last_gnt_d  = gnt1;
            log_idx_d   = log_idx_q + 16'd1;
            if (log_idx_q + 16'd1 == LOG_SIZE) begin
                state_d     = ST_FULL;
                flush_req_d = 1'b1;
            end
        end
    end

    always_comb begin
        grant_en = (state_q == ST_RUN) && !kill;
        gnt0     = grant_en && req0 && (!req1 || last_gnt_q);
        gnt1     = grant_en && req1 && (!req0 || !last_gnt_q);
        log_full = (state_q == ST_FULL);
    end

    assign log_we    = log_we_q;
    assign log_addr  = log_addr_q;
    assign log_wdata = log_wdata_q;
    assign log_idx   = log_idx_q;
    assign flush_req = flush_req_q;

endmodule

// File: tb/tb_cflog_write_arbiter.sv
// Directed bench for cflog_write_arbiter with a 4-entry log so fill, flush and kill
// paths are reached quickly.
module tb_cflog_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1;
    logic        log_we;
    logic [15:0] log_addr, log_wdata, log_idx;
    logic        log_full, flush_req;
    logic        flush_ack, kill;

    int errors = 0;
    int checks = 0;

    cflog_write_arbiter #(
        .LOG_MIN  (16'h01b0),
        .LOG_SIZE (16'h0004)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .log_we    (log_we),
        .log_addr  (log_addr),
        .log_wdata (log_wdata),
        .log_idx   (log_idx),
        .log_full  (log_full),
        .flush_req (flush_req),
        .flush_ack (flush_ack),
        .kill      (kill)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic check_write(input string tag, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] idx);
        check_eq({tag, "_we"}, {31'd0, log_we}, 32'd1);
        check_eq({tag, "_addr"}, {16'd0, log_addr}, {16'd0, addr});
        check_eq({tag, "_wdata"}, {16'd0, log_wdata}, {16'd0, wdata});
        check_eq({tag, "_idx"}, {16'd0, log_idx}, {16'd0, idx});
    endtask

    logic [15:0] exp_addr [4];
    logic        exp_g1   [4];

    initial begin
        exp_addr[0] = 16'h01b0; exp_addr[1] = 16'h01b2;
        exp_addr[2] = 16'h01b4; exp_addr[3] = 16'h01b6;
        exp_g1[0] = 1'b0; exp_g1[1] = 1'b1; exp_g1[2] = 1'b0; exp_g1[3] = 1'b1;

        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 16'h0; data1 = 16'h0;
        flush_ack = 1'b0; kill = 1'b0;
        #2;
        check_eq("rst_we", {31'd0, log_we}, 32'd0);
        check_eq("rst_addr", {16'd0, log_addr}, 32'd0);
        check_eq("rst_wdata", {16'd0, log_wdata}, 32'd0);
        check_eq("rst_idx", {16'd0, log_idx}, 32'd0);
        check_eq("rst_full", {31'd0, log_full}, 32'd0);
        check_eq("rst_flush", {31'd0, flush_req}, 32'd0);
        at_neg();
        at_neg();
        reset_n = 1'b1;

        // single producer 0
        after_pos();
        req0 = 1'b1; data0 = 16'hC0DE;
        at_neg();
        check_eq("single_gnt0", {31'd0, gnt0}, 32'd1);
        check_eq("single_gnt1", {31'd0, gnt1}, 32'd0);
        after_pos();
        req0 = 1'b0;
        check_write("single", 16'h01b0, 16'hC0DE, 16'd1);
        after_pos();
        check_eq("single_we_drop", {31'd0, log_we}, 32'd0);

        // producer 1 alone, then producer 0 alone
        req1 = 1'b1; data1 = 16'h1111;
        at_neg();
        check_eq("solo1_gnt1", {31'd0, gnt1}, 32'd1);
        after_pos();
        req1 = 1'b0;
        check_write("solo1", 16'h01b2, 16'h1111, 16'd2);
        req0 = 1'b1; data0 = 16'h2222;
        after_pos();
        req0 = 1'b0;
        check_write("solo0", 16'h01b4, 16'h2222, 16'd3);

        // async reset between edges with log_idx=3
        at_neg();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("areset_we", {31'd0, log_we}, 32'd0);
        check_eq("areset_addr", {16'd0, log_addr}, 32'd0);
        check_eq("areset_wdata", {16'd0, log_wdata}, 32'd0);
        check_eq("areset_idx", {16'd0, log_idx}, 32'd0);
        after_pos();
        reset_n = 1'b1;

        // contention: round-robin 0,1,0,1 then full
        req0 = 1'b1; data0 = 16'hAAAA;
        req1 = 1'b1; data1 = 16'hBBBB;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check_eq($sformatf("rr%0d_gnt0", k), {31'd0, gnt0}, {31'd0, !exp_g1[k]});
            check_eq($sformatf("rr%0d_gnt1", k), {31'd0, gnt1}, {31'd0, exp_g1[k]});
            after_pos();
            if (k == 3) req0 = 1'b0;
            check_write($sformatf("rr%0d", k), exp_addr[k],
                        exp_g1[k] ? 16'hBBBB : 16'hAAAA, 16'(k + 1));
        end
        check_eq("fill_full", {31'd0, log_full}, 32'd1);
        check_eq("fill_flush", {31'd0, flush_req}, 32'd1);

        // stall while FULL with req1 held
        for (int k = 0; k < 10; k++) begin
            at_neg();
            check_eq($sformatf("stall%0d_gnt1", k), {31'd0, gnt1}, 32'd0);
            after_pos();
            check_eq($sformatf("stall%0d_we", k), {31'd0, log_we}, 32'd0);
        end
        check_eq("stall_flush", {31'd0, flush_req}, 32'd1);
        check_eq("stall_idx", {16'd0, log_idx}, 32'd4);

        flush_ack = 1'b1;
        at_neg();
        check_eq("ack_gnt1", {31'd0, gnt1}, 32'd0);
        after_pos();
        flush_ack = 1'b0;
        check_eq("ack_idx", {16'd0, log_idx}, 32'd0);
        check_eq("ack_full", {31'd0, log_full}, 32'd0);
        check_eq("ack_flush", {31'd0, flush_req}, 32'd0);
        at_neg();
        check_eq("resume_gnt1", {31'd0, gnt1}, 32'd1);
        after_pos();
        req1 = 1'b0;
        check_write("resume", 16'h01b0, 16'hBBBB, 16'd1);

        // refill with producer 0 only
        req0 = 1'b1; data0 = 16'h5A5A;
        for (int k = 1; k < 4; k++) begin
            after_pos();
            check_write($sformatf("refill%0d", k), exp_addr[k], 16'h5A5A, 16'(k + 1));
        end
        req0 = 1'b0;
        check_eq("refill_full", {31'd0, log_full}, 32'd1);

        // kill together with flush_ack while FULL
        kill = 1'b1; flush_ack = 1'b1;
        after_pos();
        kill = 1'b0; flush_ack = 1'b0;
        check_eq("kfull_flush", {31'd0, flush_req}, 32'd0);
        check_eq("kfull_full", {31'd0, log_full}, 32'd0);
        check_eq("kfull_idx", {16'd0, log_idx}, 32'd0);
        check_eq("kfull_we", {31'd0, log_we}, 32'd0);
        req0 = 1'b1; data0 = 16'h7777;
        at_neg();
        check_eq("kfull_run_gnt0", {31'd0, gnt0}, 32'd1);
        after_pos();
        req0 = 1'b0;
        check_write("kfull_run", 16'h01b0, 16'h7777, 16'd1);

        // kill versus grant
        kill = 1'b1; req0 = 1'b1;
        at_neg();
        check_eq("kgnt_gnt0", {31'd0, gnt0}, 32'd0);
        after_pos();
        check_eq("kgnt_we", {31'd0, log_we}, 32'd0);
        check_eq("kgnt_idx", {16'd0, log_idx}, 32'd0);
        after_pos();
        check_eq("kgnt_idx_hold", {16'd0, log_idx}, 32'd0);
        kill = 1'b0;
        at_neg();
        check_eq("kgnt_release_gnt0", {31'd0, gnt0}, 32'd1);
        after_pos();
        req0 = 1'b0;
        check_write("kgnt_release", 16'h01b0, 16'h7777, 16'd1);

        // kill on the grant that would fill the log
        req0 = 1'b1; data0 = 16'h3333;
        after_pos();
        after_pos();
        check_eq("kfill_pre_idx", {16'd0, log_idx}, 32'd3);
        kill = 1'b1;
        at_neg();
        check_eq("kfill_gnt0", {31'd0, gnt0}, 32'd0);
        after_pos();
        kill = 1'b0; req0 = 1'b0;
        check_eq("kfill_we", {31'd0, log_we}, 32'd0);
        check_eq("kfill_idx", {16'd0, log_idx}, 32'd0);
        check_eq("kfill_full", {31'd0, log_full}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
